// File: rtl/quadrature_encoder_reader.sv
// Avalon-MM quadrature encoder reader: synchronizes and glitch-filters A/B/I, x4-decodes
// into a signed 32-bit position, latches on index, measures velocity and counts errors.
module quadrature_encoder_reader (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset,
    input  logic [31:0] avs_ctrl_writedata,
    output logic [31:0] avs_ctrl_readdata,
    input  logic [3:0]  avs_ctrl_byteenable,
    input  logic [2:0]  avs_ctrl_address,
    input  logic        avs_ctrl_write,
    input  logic        avs_ctrl_read,
    output logic        avs_ctrl_waitrequest,
    input  logic        ENC_A,
    input  logic        ENC_B,
    input  logic        ENC_I
);
    localparam logic [2:0] ADDR_POSITION   = 3'd0;
    localparam logic [2:0] ADDR_CONTROL    = 3'd1;
    localparam logic [2:0] ADDR_FILTER     = 3'd2;
    localparam logic [2:0] ADDR_VEL_PERIOD = 3'd3;
    localparam logic [2:0] ADDR_VELOCITY   = 3'd4;
    localparam logic [2:0] ADDR_INDEX_POS  = 3'd5;
    localparam logic [2:0] ADDR_STATUS     = 3'd6;

    logic [2:0]  r_sync1;
    logic [2:0]  r_sync2;
    logic [2:0]  w_filt;
    logic [7:0]  r_filter_len;
    logic        r_enable;
    logic        r_invert;
    logic        r_clr_on_index;
    logic [31:0] r_position;
    logic [31:0] r_index_pos;
    logic [31:0] r_vel_period;
    logic [31:0] r_vel_cnt;
    logic [31:0] r_vel_acc;
    logic [31:0] r_velocity;
    logic [1:0]  r_ab_prev;
    logic        r_i_prev;
    logic        r_dir;
    logic        r_index_seen;
    logic [7:0]  r_err_cnt;
    logic [31:0] r_readdata;

    logic        w_wr_position;
    logic        w_wr_control;
    logic        w_wr_filter;
    logic        w_wr_vel_period;
    logic        w_wr_status;
    logic [1:0]  w_ab_cur;
    logic        w_fwd;
    logic        w_rev;
    logic        w_up;
    logic        w_dn;
    logic        w_err;
    logic        w_index_rise;
    logic [31:0] w_step;
    logic [31:0] w_rd_mux;

    function automatic logic [31:0] f_merge(input logic [31:0] old_val,
                                            input logic [31:0] new_val,
                                            input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

    assign avs_ctrl_waitrequest = 1'b0;
    assign avs_ctrl_readdata    = r_readdata;

    assign w_wr_position   = avs_ctrl_write && (avs_ctrl_address == ADDR_POSITION);
    assign w_wr_control    = avs_ctrl_write && (avs_ctrl_address == ADDR_CONTROL);
    assign w_wr_filter     = avs_ctrl_write && (avs_ctrl_address == ADDR_FILTER);
    assign w_wr_vel_period = avs_ctrl_write && (avs_ctrl_address == ADDR_VEL_PERIOD);
    assign w_wr_status     = avs_ctrl_write && (avs_ctrl_address == ADDR_STATUS);

    // Two-flop synchronizer; bit 0 = A, bit 1 = B, bit 2 = I
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= {ENC_I, ENC_B, ENC_A};
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_filter
            logic [7:0] r_cnt;
            logic       r_val;
            always_ff @(posedge csi_MCLK_clk) begin
                if (rsi_MRST_reset) begin
                    r_cnt <= '0;
                    r_val <= 1'b0;
                end else if (r_sync2[gi] != r_val) begin
                    if (r_cnt == r_filter_len) begin
                        r_val <= r_sync2[gi];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
            assign w_filt[gi] = r_val;
        end
    endgenerate

    // Forward order on {A,B} is 00 -> 10 -> 11 -> 01 -> 00
    assign w_ab_cur = {w_filt[0], w_filt[1]};
    assign w_fwd = ((r_ab_prev == 2'b00) && (w_ab_cur == 2'b10)) ||
                   ((r_ab_prev == 2'b10) && (w_ab_cur == 2'b11)) ||
                   ((r_ab_prev == 2'b11) && (w_ab_cur == 2'b01)) ||
                   ((r_ab_prev == 2'b01) && (w_ab_cur == 2'b00));
    assign w_rev = ((r_ab_prev == 2'b10) && (w_ab_cur == 2'b00)) ||
                   ((r_ab_prev == 2'b11) && (w_ab_cur == 2'b10)) ||
                   ((r_ab_prev == 2'b01) && (w_ab_cur == 2'b11)) ||
                   ((r_ab_prev == 2'b00) && (w_ab_cur == 2'b01));
    assign w_up  = r_enable && ((w_fwd && !r_invert) || (w_rev && r_invert));
    assign w_dn  = r_enable && ((w_rev && !r_invert) || (w_fwd && r_invert));
    assign w_err = r_enable && ((r_ab_prev ^ w_ab_cur) == 2'b11);
    assign w_index_rise = r_enable && w_filt[2] && !r_i_prev;
    assign w_step = w_up ? 32'h0000_0001 : (w_dn ? 32'hFFFF_FFFF : 32'h0000_0000);

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            r_filter_len   <= '0;
            r_enable       <= 1'b0;
            r_invert       <= 1'b0;
            r_clr_on_index <= 1'b0;
        end else begin
            if (w_wr_control) begin
                r_enable       <= avs_ctrl_writedata[0];
                r_invert       <= avs_ctrl_writedata[1];
                r_clr_on_index <= avs_ctrl_writedata[2];
            end
            if (w_wr_filter && avs_ctrl_byteenable[0]) begin
                r_filter_len <= avs_ctrl_writedata[7:0];
            end
        end
    end

    // Position: bus write beats index clear, which beats the decoded step
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            r_position   <= '0;
            r_index_pos  <= '0;
            r_ab_prev    <= '0;
            r_i_prev     <= 1'b0;
            r_dir        <= 1'b0;
            r_index_seen <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_ab_prev <= w_ab_cur;
            r_i_prev  <= w_filt[2];
            if (w_wr_position) begin
                r_position <= f_merge(r_position, avs_ctrl_writedata, avs_ctrl_byteenable);
            end else if (w_index_rise && r_clr_on_index) begin
                r_position <= '0;
            end else begin
                r_position <= r_position + w_step;
            end
            if (w_index_rise) begin
                r_index_pos <= r_position;
            end
            if (w_up || w_dn) begin
                r_dir <= w_up;
            end
            if (w_wr_status && avs_ctrl_writedata[1]) begin
                r_index_seen <= 1'b0;
            end else if (w_index_rise) begin
                r_index_seen <= 1'b1;
            end
            if (w_wr_status && avs_ctrl_writedata[2]) begin
                r_err_cnt <= '0;
            end else if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Velocity window: the counter is loaded with P and expires on the cycle it reads 1
    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            r_vel_period <= '0;
            r_vel_cnt    <= '0;
            r_vel_acc    <= '0;
            r_velocity   <= '0;
        end else if (w_wr_vel_period) begin
            r_vel_period <= f_merge(r_vel_period, avs_ctrl_writedata, avs_ctrl_byteenable);
            r_vel_cnt    <= f_merge(r_vel_period, avs_ctrl_writedata, avs_ctrl_byteenable);
            r_vel_acc    <= '0;
        end else if (r_vel_period == 32'd0) begin
            r_vel_cnt <= '0;
            r_vel_acc <= '0;
        end else if (r_vel_cnt <= 32'd1) begin
            r_velocity <= r_vel_acc + w_step;
            r_vel_acc  <= '0;
            r_vel_cnt  <= r_vel_period;
        end else begin
            r_vel_acc <= r_vel_acc + w_step;
            r_vel_cnt <= r_vel_cnt - 32'd1;
        end
    end

    always_comb begin
        w_rd_mux = 32'h0000_0000;
        case (avs_ctrl_address)
            ADDR_POSITION:   w_rd_mux = r_position;
            ADDR_CONTROL:    w_rd_mux = {29'd0, r_clr_on_index, r_invert, r_enable};
            ADDR_FILTER:     w_rd_mux = {24'd0, r_filter_len};
            ADDR_VEL_PERIOD: w_rd_mux = r_vel_period;
            ADDR_VELOCITY:   w_rd_mux = r_velocity;
            ADDR_INDEX_POS:  w_rd_mux = r_index_pos;
            ADDR_STATUS:     w_rd_mux = {16'd0, r_err_cnt, 6'd0, r_index_seen, r_dir};
            default:         w_rd_mux = 32'h0000_0000;
        endcase
    end

    always_ff @(posedge csi_MCLK_clk) begin
        if (rsi_MRST_reset) begin
            r_readdata <= '0;
        end else if (!avs_ctrl_write && avs_ctrl_read) begin
            r_readdata <= w_rd_mux;
        end
    end

endmodule

// File: tb/tb_quadrature_encoder_reader.sv
// Bench for quadrature_encoder_reader: register-map vector table, then directed
// sequences for counting, filtering, wrap, index, velocity, error saturation and reset.
module tb_quadrature_encoder_reader;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [2:0]  addr;
    logic        wr;
    logic        rd;
    logic        waitreq;
    logic        enc_a;
    logic        enc_b;
    logic        enc_i;

    int n_vec = 0;
    int n_miscmp = 0;
    logic [1:0] ab = 2'b00;

    typedef struct {
        bit          wr;
        logic [2:0]  addr;
        logic [31:0] data;
        logic [3:0]  be;
        logic [31:0] exp;
    } vec_t;
    vec_t vq[$];

    quadrature_encoder_reader dut (
        .csi_MCLK_clk         (clk),
        .rsi_MRST_reset       (rst),
        .avs_ctrl_writedata   (wdata),
        .avs_ctrl_readdata    (rdata),
        .avs_ctrl_byteenable  (be),
        .avs_ctrl_address     (addr),
        .avs_ctrl_write       (wr),
        .avs_ctrl_read        (rd),
        .avs_ctrl_waitrequest (waitreq),
        .ENC_A                (enc_a),
        .ENC_B                (enc_b),
        .ENC_I                (enc_i)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (waitreq !== 1'b0) begin
            n_miscmp++;
            $display("FAIL waitrequest: got %b required 0", waitreq);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d, input logic [3:0] b);
        addr = a; wdata = d; be = b; wr = 1'b1;
        tick(1);
        wr = 1'b0; be = 4'h0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        addr = a; rd = 1'b1;
        tick(1);
        rd = 1'b0;
        d = rdata;
    endtask

    task automatic read_check(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        check(name, v, exp);
    endtask

    task automatic quad_fwd(input int hold);
        case (ab)
            2'b00:   ab = 2'b10;
            2'b10:   ab = 2'b11;
            2'b11:   ab = 2'b01;
            default: ab = 2'b00;
        endcase
        enc_a = ab[1]; enc_b = ab[0];
        tick(hold);
    endtask

    task automatic add(input bit w, input logic [2:0] a, input logic [31:0] d,
                       input logic [3:0] b, input logic [31:0] e);
        vec_t v;
        v.wr = w; v.addr = a; v.data = d; v.be = b; v.exp = e;
        vq.push_back(v);
    endtask

    initial begin
        logic [31:0] v;
        rst = 1'b1; wdata = '0; be = '0; addr = '0; wr = 1'b0; rd = 1'b0;
        enc_a = 1'b0; enc_b = 1'b0; enc_i = 1'b0;

        for (int a = 0; a < 8; a++) add(1'b0, 3'(a), 32'h0, 4'h0, 32'h0);
        add(1'b1, 3'd1, 32'hFFFF_FFFF, 4'hF, 32'h0);
        add(1'b0, 3'd1, 32'h0, 4'h0, 32'h0000_0007);
        add(1'b1, 3'd2, 32'h0000_1234, 4'hF, 32'h0);
        add(1'b0, 3'd2, 32'h0, 4'h0, 32'h0000_0034);
        add(1'b1, 3'd2, 32'h0000_00FF, 4'h0, 32'h0);
        add(1'b0, 3'd2, 32'h0, 4'h0, 32'h0000_0034);
        add(1'b1, 3'd3, 32'hDEAD_BEEF, 4'h5, 32'h0);
        add(1'b0, 3'd3, 32'h0, 4'h0, 32'h00AD_00EF);
        add(1'b1, 3'd0, 32'h1234_5678, 4'hA, 32'h0);
        add(1'b0, 3'd0, 32'h0, 4'h0, 32'h1200_5600);
        add(1'b1, 3'd7, 32'hFFFF_FFFF, 4'hF, 32'h0);
        add(1'b0, 3'd7, 32'h0, 4'h0, 32'h0);
        add(1'b1, 3'd4, 32'h0000_1234, 4'hF, 32'h0);
        add(1'b0, 3'd4, 32'h0, 4'h0, 32'h0);
        add(1'b1, 3'd5, 32'h0000_5678, 4'hF, 32'h0);
        add(1'b0, 3'd5, 32'h0, 4'h0, 32'h0);
        add(1'b1, 3'd6, 32'hFFFF_FFFF, 4'hF, 32'h0);
        add(1'b0, 3'd6, 32'h0, 4'h0, 32'h0);
        add(1'b1, 3'd1, 32'h0000_0001, 4'hF, 32'h0);
        add(1'b1, 3'd2, 32'h0000_0000, 4'hF, 32'h0);
        add(1'b1, 3'd3, 32'h0000_0000, 4'hF, 32'h0);
        add(1'b1, 3'd0, 32'h0000_0000, 4'hF, 32'h0);
        add(1'b0, 3'd0, 32'h0, 4'h0, 32'h0);
        add(1'b0, 3'd3, 32'h0, 4'h0, 32'h0);

        tick(3);
        rst = 1'b0;
        tick(2);

        foreach (vq[i]) begin
            if (vq[i].wr) begin
                bus_write(vq[i].addr, vq[i].data, vq[i].be);
            end else begin
                bus_read(vq[i].addr, v);
                check($sformatf("vec%0d_addr%0d", i, vq[i].addr), v, vq[i].exp);
            end
        end

        // Eight forward steps, then the same motion with invert set
        for (int s = 0; s < 8; s++) quad_fwd(10);
        read_check("fwd8_position", 3'd0, 32'd8);
        read_check("fwd8_status", 3'd6, 32'h0000_0001);
        bus_write(3'd1, 32'h3, 4'hF);
        for (int s = 0; s < 8; s++) quad_fwd(10);
        read_check("invert_position", 3'd0, 32'd0);
        bus_write(3'd1, 32'h1, 4'hF);

        // Filter N=3: short glitch rejected, then latency of a held edge
        bus_write(3'd2, 32'h3, 4'hF);
        enc_a = 1'b1;
        tick(2);
        enc_a = 1'b0;
        tick(12);
        read_check("glitch_position", 3'd0, 32'd0);
        ab = 2'b10;
        enc_a = 1'b1;
        addr = 3'd0; rd = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick(1);
            check($sformatf("latency_rd%0d", j), rdata, (j <= 7) ? 32'd0 : 32'd1);
        end
        rd = 1'b0;
        tick(5);

        // Wrap past the positive limit, then a single-byte write
        bus_write(3'd0, 32'h7FFF_FFFF, 4'hF);
        quad_fwd(12);
        read_check("wrap_position", 3'd0, 32'h8000_0000);
        bus_write(3'd0, 32'h0000_0055, 4'h1);
        read_check("byte_write_position", 3'd0, 32'h8000_0055);

        // Index with clear-on-index
        bus_write(3'd2, 32'h0, 4'hF);
        bus_write(3'd1, 32'h5, 4'hF);
        bus_write(3'd0, 32'd100, 4'hF);
        enc_i = 1'b1;
        tick(8);
        enc_i = 1'b0;
        tick(8);
        read_check("index_pos", 3'd5, 32'd100);
        read_check("index_position", 3'd0, 32'd0);
        read_check("index_status", 3'd6, 32'h0000_0003);
        bus_write(3'd6, 32'h2, 4'hF);
        read_check("index_seen_clear", 3'd6, 32'h0000_0001);

        // Velocity over a 1000-cycle window, one step every 50 cycles
        bus_write(3'd1, 32'h1, 4'hF);
        bus_write(3'd3, 32'd1000, 4'hF);
        for (int s = 0; s < 70; s++) quad_fwd(50);
        read_check("velocity", 3'd4, 32'd20);
        read_check("velocity_position", 3'd0, 32'd70);

        // Both channels toggling together: errors saturate, position holds
        for (int s = 0; s < 300; s++) begin
            ab = ab ^ 2'b11;
            enc_a = ab[1]; enc_b = ab[0];
            tick(6);
        end
        read_check("err_status", 3'd6, 32'h0000_FF01);
        read_check("err_position", 3'd0, 32'd70);
        bus_write(3'd6, 32'h4, 4'hF);
        read_check("err_clear", 3'd6, 32'h0000_0001);

        // Reset in the middle of operation
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        read_check("midreset_position", 3'd0, 32'd0);
        read_check("midreset_vel_period", 3'd3, 32'd0);
        read_check("midreset_control", 3'd1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule

// File: doc/quadrature_encoder_reader.md
# quadrature_encoder_reader

Avalon-MM slave that reads an incremental quadrature encoder (A/B/Index) mounted on a motor shaft, the sensing counterpart to the step motor driver. It synchronizes and glitch-filters the encoder inputs, x4-decodes them into a signed 32-bit position, latches position on index, measures velocity over a programmable window, and counts illegal transitions. It sits on the Qsys control bus beside the motor drivers; everything runs on one clock.

## Interface
- No parameters.
- csi_MCLK_clk  in  1  system and bus clock; all logic on rising edge
- rsi_MRST_reset  in  1  synchronous, active-high reset
- avs_ctrl_writedata  in  32  write data
- avs_ctrl_readdata  out  32  registered read data, valid 1 cycle after read
- avs_ctrl_byteenable  in  4  byte lanes for writes to regs 0, 2, 3
- avs_ctrl_address  in  3  word address
- avs_ctrl_write  in  1  write strobe
- avs_ctrl_read  in  1  read strobe
- avs_ctrl_waitrequest  out  1  tied 0
- ENC_A, ENC_B, ENC_I  in  1 each  asynchronous encoder inputs

## Operation
- Register map (word address):
  - 0 POSITION R/W signed 32; write loads position per byteenable.
  - 1 CONTROL R/W: bit0 enable, bit1 invert direction, bit2 clear-on-index; others read 0.
  - 2 FILTER R/W [7:0] filter length N.
  - 3 VEL_PERIOD R/W 32-bit window length P in clocks.
  - 4 VELOCITY RO signed 32 counts in last completed window.
  - 5 INDEX_POS RO position latched at last index rising edge.
  - 6 STATUS: bit0 last direction (1 = forward), bit1 index seen (sticky; write 1 to bit1 clears), bits[15:8] error count, saturating at 255 (write 1 to bit2 clears). Other bits read 0.
  - 7 reserved: reads 0, writes ignored.
- Read and write are mutually exclusive; write is checked first.
- Sync: each input passes through 2 flops.
- Filter per channel: the filtered value starts at 0. While the synced value differs from the filtered value, a counter increments. When the counter equals N, the filtered value takes the synced value and the counter clears. The counter also clears whenever the two are equal. N=0 means update on the first differing cycle.
- Decode {A,B} filtered, previous vs current, forward sequence 00→10→11→01→00:
  - forward step +1, reverse step -1; invert swaps the sign.
  - both bits changing is an error: no count, error count +1.
  - previous state is tracked even when disabled.
  - step, error, index and velocity accumulation only act when enable=1.
- Index: on a filtered I rising edge with enable=1:
  - INDEX_POS takes the current position, before any step or clear this cycle.
  - index-seen is set.
  - if clear-on-index, position becomes 0.
- Position priority in one cycle: bus write > index clear > decode step. The losing step is discarded.
- Position wraps modulo 2^32 (0x7FFFFFFF + 1 = 0x80000000).
- Velocity: a down-counter reloads with P. Each enabled step adds ±1 to the accumulator.
  - When the down-counter expires (every P cycles), VELOCITY takes accumulator plus this cycle's step, then the accumulator clears.
  - P=0 freezes VELOCITY and holds the accumulator at 0.
  - Writing VEL_PERIOD restarts the window.

## Timing
- Reset: all registers, readdata, filtered values, counters, accumulator and the velocity timer are 0. Reset mid-operation discards all state in one cycle.
- Input edge to position update: 2 (sync) + N+1 (filter) + 1 (decode register) = N+4 cycles.
- Read latency is 1. Write is visible on the next cycle's read. waitrequest is always 0.
- Error count saturates at 255; further errors are ignored.
- Clear-error and index-seen clear in the same cycle as a new event: the clear wins.

## Test plan
- Reset, then read all 8 addresses → all 0; waitrequest never high.
- N=0, enable=1, drive 8 forward quadrature steps, 10 clocks apart → POSITION=8, STATUS bit0=1. Set invert and drive the same sequence → POSITION=0.
- N=3, apply a 2-cycle glitch on A → no count. Hold A for 4+ cycles → +1 count, first visible 7 cycles after the edge.
- Write POSITION=0x7FFFFFFF, one forward step → 0x80000000. Write the low byte only (byteenable=0001, data 0x55) → 0x80000055.
- Set clear-on-index, position at 100, pulse I → INDEX_POS=100, POSITION=0, STATUS bit1=1. Write 0x2 to STATUS → bit1=0.
- P=1000, steps every 50 clocks forward → VELOCITY=20. Toggle A and B together 300 times → error count=255, position unchanged.
